// File: rtl/mig_app_responder.sv
// mig_app_responder
// Cycle-level responder for the MIG 7-series native app interface. It stands in for the
// MIG IP plus DDR3 device so client logic can run in fast benches or DDR-less builds.
// Commands and write-data beats are queued separately and paired strictly in order.
// Writes land in an internal word array. Reads come back in command order after a fixed
// RD_LAT pipeline.
// Optional feature: define RESP_STALL_EN to add LFSR-driven random ready back-pressure.
module mig_app_responder #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 128,
  parameter int MEM_AW      = 10,
  parameter int CMDQ_DEPTH  = 4,
  parameter int WDFQ_DEPTH  = 4,
  parameter int RD_LAT      = 4,
  parameter int INIT_CYCLES = 64
) (
  input  logic                  clk_ref_i,
  input  logic                  reset_rtl_0,
  input  logic [ADDR_W-1:0]     app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_W-1:0]     app_wdf_data,
  input  logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  init_calib_complete,
  output logic                  cmd_err
);

  localparam int NB     = DATA_W / 8;
  localparam int NWORDS = 1 << MEM_AW;
  localparam int CPW    = $clog2(CMDQ_DEPTH);
  localparam int CCW    = $clog2(CMDQ_DEPTH + 1);
  localparam int WPW    = $clog2(WDFQ_DEPTH);
  localparam int WCW    = $clog2(WDFQ_DEPTH + 1);
  localparam int ICW    = $clog2(INIT_CYCLES + 1);

  // A queued command only needs its direction and the word it targets.
  typedef struct packed {
    logic              is_rd;
    logic [MEM_AW-1:0] idx;
  } cmd_t;

  // Storage arrays: no reset. Memory contents deliberately survive reset.
  logic [DATA_W-1:0] mem      [NWORDS];
  cmd_t              cmd_ram  [CMDQ_DEPTH];
  logic [DATA_W-1:0] wdf_dram [WDFQ_DEPTH];
  logic [NB-1:0]     wdf_mram [WDFQ_DEPTH];

  // Queue pointers and occupancy.
  logic [CPW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CCW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [WPW-1:0] wdf_wp_q, wdf_wp_d, wdf_rp_q, wdf_rp_d;
  logic [WCW-1:0] wdf_cnt_q, wdf_cnt_d;

  // Init counter, calibration flag and sticky error flag.
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  logic           calib_q, calib_d;
  logic           err_q, err_d;

  // Read return pipeline; stage 0 is loaded at issue.
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_dat_q [RD_LAT];
  logic [DATA_W-1:0] rd_dat_d [RD_LAT];

  // Handshake, execute-stage and datapath nets.
  logic              stall_cmd, stall_wdf;
  logic              cmd_full, wdf_full;
  logic              cmd_acc, cmd_legal, cmd_push, cmd_pop;
  logic              wdf_push, wdf_pop;
  logic              cmd_nonempty, wdf_nonempty;
  logic              exec_rd, exec_wr;
  cmd_t              cmd_new, cmd_head;
  logic [DATA_W-1:0] head_word, wr_word;
  logic [DATA_W-1:0] wdf_head_data;
  logic [NB-1:0]     wdf_head_mask;
  logic              addr_unused;

  // Address bits outside the word index are ignored, which gives aliasing.
  assign addr_unused = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0]};

`ifdef RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Advance the x^16+x^14+x^13+x^11+1 stall LFSR once calibration is complete.
  always_comb begin
    lfsr_d = lfsr_q;
    if (calib_q) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Stall LFSR register; reseeded on every reset.
  always_ff @(posedge clk_ref_i) begin
    if (!reset_rtl_0) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_cmd = lfsr_q[0];
  assign stall_wdf = lfsr_q[1];
`else
  assign stall_cmd = 1'b0;
  assign stall_wdf = 1'b0;
`endif

  // Ready signals depend only on calibration and queue occupancy, never on this cycle's inputs.
  always_comb begin
    cmd_full     = (cmd_cnt_q == CCW'(CMDQ_DEPTH));
    wdf_full     = (wdf_cnt_q == WCW'(WDFQ_DEPTH));
    cmd_nonempty = (cmd_cnt_q != '0);
    wdf_nonempty = (wdf_cnt_q != '0);
    app_rdy      = calib_q && !cmd_full && !stall_cmd;
    app_wdf_rdy  = calib_q && !wdf_full && !stall_wdf;
  end

  // Acceptance. Illegal commands complete the handshake but are never queued.
  always_comb begin
    cmd_acc       = app_en && app_rdy;
    cmd_legal     = (app_cmd == 3'b000) || (app_cmd == 3'b001);
    cmd_push      = cmd_acc && cmd_legal;
    wdf_push      = app_wdf_wren && app_wdf_rdy;
    cmd_new.is_rd = app_cmd[0];
    cmd_new.idx   = app_addr[MEM_AW+2:3];
  end

  // Execute stage. A read issues at once; a write waits at the head for its data beat.
  always_comb begin
    cmd_head      = cmd_ram[cmd_rp_q];
    wdf_head_data = wdf_dram[wdf_rp_q];
    wdf_head_mask = wdf_mram[wdf_rp_q];
    head_word     = mem[cmd_head.idx];
    exec_rd       = cmd_nonempty && cmd_head.is_rd;
    exec_wr       = cmd_nonempty && !cmd_head.is_rd && wdf_nonempty;
    cmd_pop       = exec_rd || exec_wr;
    wdf_pop       = exec_wr;
  end

  // Merge the write beat into the stored word. A set mask bit keeps the old byte.
  always_comb begin
    wr_word = head_word;
    for (int b = 0; b < NB; b++) begin
      if (!wdf_head_mask[b]) begin
        wr_word[b*8 +: 8] = wdf_head_data[b*8 +: 8];
      end
    end
  end

  // Command queue pointer and count bookkeeping.
  always_comb begin
    cmd_wp_d  = cmd_wp_q;
    cmd_rp_d  = cmd_rp_q;
    cmd_cnt_d = cmd_cnt_q;
    if (cmd_push) cmd_wp_d = cmd_wp_q + CPW'(1);
    if (cmd_pop)  cmd_rp_d = cmd_rp_q + CPW'(1);
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_d = cmd_cnt_q + CCW'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - CCW'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase
  end

  // Write-data queue pointer and count bookkeeping.
  always_comb begin
    wdf_wp_d  = wdf_wp_q;
    wdf_rp_d  = wdf_rp_q;
    wdf_cnt_d = wdf_cnt_q;
    if (wdf_push) wdf_wp_d = wdf_wp_q + WPW'(1);
    if (wdf_pop)  wdf_rp_d = wdf_rp_q + WPW'(1);
    case ({wdf_push, wdf_pop})
      2'b10:   wdf_cnt_d = wdf_cnt_q + WCW'(1);
      2'b01:   wdf_cnt_d = wdf_cnt_q - WCW'(1);
      default: wdf_cnt_d = wdf_cnt_q;
    endcase
  end

  // Saturating init counter. Calibration completes on the INIT_CYCLES-th edge after release.
  // The sticky error flag catches illegal commands and wren/end mismatches.
  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_cnt_q != ICW'(INIT_CYCLES)) begin
      init_cnt_d = init_cnt_q + ICW'(1);
    end
    calib_d = (init_cnt_d == ICW'(INIT_CYCLES));
    err_d   = err_q || (cmd_acc && !cmd_legal) || (app_wdf_wren != app_wdf_end);
  end

  // Shift the read return pipeline. The memory word is captured at issue.
  always_comb begin
    rd_vld_d[0] = exec_rd;
    rd_dat_d[0] = exec_rd ? head_word : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_dat_d[i] = rd_dat_q[i-1];
    end
  end

  // Control and pipeline registers. Reset flushes queues, pending reads and init state.
  always_ff @(posedge clk_ref_i) begin
    if (!reset_rtl_0) begin
      cmd_wp_q   <= '0;
      cmd_rp_q   <= '0;
      cmd_cnt_q  <= '0;
      wdf_wp_q   <= '0;
      wdf_rp_q   <= '0;
      wdf_cnt_q  <= '0;
      init_cnt_q <= '0;
      calib_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
    end else begin
      cmd_wp_q   <= cmd_wp_d;
      cmd_rp_q   <= cmd_rp_d;
      cmd_cnt_q  <= cmd_cnt_d;
      wdf_wp_q   <= wdf_wp_d;
      wdf_rp_q   <= wdf_rp_d;
      wdf_cnt_q  <= wdf_cnt_d;
      init_cnt_q <= init_cnt_d;
      calib_q    <= calib_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
      for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= rd_dat_d[i];
    end
  end

  // Queue storage writes. The pointers are reset, so stale entries are harmless.
  always_ff @(posedge clk_ref_i) begin
    if (cmd_push) cmd_ram[cmd_wp_q] <= cmd_new;
    if (wdf_push) begin
      wdf_dram[wdf_wp_q] <= app_wdf_data;
      wdf_mram[wdf_wp_q] <= app_wdf_mask;
    end
  end

  // Word array update. It is blocked during reset but never cleared.
  always_ff @(posedge clk_ref_i) begin
    if (reset_rtl_0 && exec_wr) begin
      mem[cmd_head.idx] <= wr_word;
    end
  end

  assign app_rd_data_valid   = rd_vld_q[RD_LAT-1];
  assign app_rd_data_end     = rd_vld_q[RD_LAT-1];
  assign app_rd_data         = rd_dat_q[RD_LAT-1];
  assign init_calib_complete = calib_q;
  assign cmd_err             = err_q;

endmodule

// File: tb/tb_mig_app_responder.sv
// tb_mig_app_responder
// Directed scenarios plus a randomized phase. A queue-level behavioural model of the
// responder predicts every output each cycle. Literal expectations pin the model.
module tb_mig_app_responder;

  localparam int ADDR_W      = 27;
  localparam int DATA_W      = 128;
  localparam int MEM_AW      = 10;
  localparam int QD          = 4;
  localparam int RD_LAT      = 4;
  localparam int INIT_CYCLES = 64;
  localparam int NWORDS      = 1 << MEM_AW;

  logic              clk_ref_i = 1'b0;
  logic              reset_rtl_0 = 1'b0;
  logic [ADDR_W-1:0] app_addr = '0;
  logic [2:0]        app_cmd = '0;
  logic              app_en = 1'b0;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data = '0;
  logic [15:0]       app_wdf_mask = '0;
  logic              app_wdf_wren = 1'b0;
  logic              app_wdf_end = 1'b0;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              init_calib_complete;
  logic              cmd_err;

  always #5 clk_ref_i = ~clk_ref_i;

  mig_app_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .CMDQ_DEPTH(QD),
    .WDFQ_DEPTH(QD), .RD_LAT(RD_LAT), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk_ref_i(clk_ref_i), .reset_rtl_0(reset_rtl_0),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
    .cmd_err(cmd_err)
  );

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  // Behavioural model state: plain queues and a word array.
  typedef struct { bit rd; int idx; } mcmd_t;
  typedef struct { logic [DATA_W-1:0] d; logic [15:0] m; } mwdf_t;
  typedef struct { int due; logic [DATA_W-1:0] d; bit known; } mrsp_t;

  mcmd_t             mcmdq[$];
  mwdf_t             mwdfq[$];
  mrsp_t             mrsp[$];
  logic [DATA_W-1:0] mmem [NWORDS];
  bit                mknown [NWORDS];
  int                mcnt = 0;
  bit                mcal = 0, merr = 0;
  bit                m_rdy = 0, m_wrdy = 0, m_valid = 0, m_known = 0;
  logic [DATA_W-1:0] m_data = '0;
  bit                pre_rdy, pre_wrdy;
  mcmd_t             mc;
  mwdf_t             mw;
  mrsp_t             mr;

  logic [DATA_W-1:0] rsp_log[$];
  int                rsp_edge[$];

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model update on every rising edge, using the inputs the DUT sees at that edge.
  always @(posedge clk_ref_i) begin
    ecount++;
    if (!reset_rtl_0) begin
      mcmdq.delete();
      mwdfq.delete();
      mrsp.delete();
      mcnt    = 0;
      mcal    = 0;
      merr    = 0;
      m_valid = 0;
    end else begin
      pre_rdy  = mcal && (mcmdq.size() < QD);
      pre_wrdy = mcal && (mwdfq.size() < QD);
      if (mcmdq.size() > 0) begin
        mc = mcmdq[0];
        if (mc.rd) begin
          mr.due   = ecount + RD_LAT - 1;
          mr.d     = mmem[mc.idx];
          mr.known = mknown[mc.idx];
          mrsp.push_back(mr);
          void'(mcmdq.pop_front());
        end else if (mwdfq.size() > 0) begin
          mw = mwdfq.pop_front();
          for (int b = 0; b < 16; b++) begin
            if (!mw.m[b]) mmem[mc.idx][b*8 +: 8] = mw.d[b*8 +: 8];
          end
          if (mw.m == 16'h0) mknown[mc.idx] = 1;
          void'(mcmdq.pop_front());
        end
      end
      if (app_en && pre_rdy) begin
        if (app_cmd == 3'd0 || app_cmd == 3'd1) begin
          mc.rd  = (app_cmd == 3'd1);
          mc.idx = int'(app_addr >> 3) % NWORDS;
          mcmdq.push_back(mc);
        end else begin
          merr = 1;
        end
      end
      if (app_wdf_wren && pre_wrdy) begin
        mw.d = app_wdf_data;
        mw.m = app_wdf_mask;
        mwdfq.push_back(mw);
      end
      if (app_wdf_wren != app_wdf_end) merr = 1;
      if (mcnt < INIT_CYCLES) mcnt++;
      if (mcnt == INIT_CYCLES) mcal = 1;
      m_valid = 0;
      if (mrsp.size() > 0 && mrsp[0].due == ecount) begin
        mr      = mrsp.pop_front();
        m_valid = 1;
        m_data  = mr.d;
        m_known = mr.known;
      end
    end
    m_rdy  = mcal && (mcmdq.size() < QD);
    m_wrdy = mcal && (mwdfq.size() < QD);
  end

  // Compare the DUT against the model every cycle, half a period after the edge.
  always @(negedge clk_ref_i) begin
    checkOutput("app_rdy", app_rdy, m_rdy);
    checkOutput("app_wdf_rdy", app_wdf_rdy, m_wrdy);
    checkOutput("init_calib_complete", init_calib_complete, mcal);
    checkOutput("cmd_err", cmd_err, merr);
    checkOutput("rd_valid", app_rd_data_valid, m_valid);
    checkOutput("rd_end", app_rd_data_end, m_valid);
    if (m_valid && m_known) checkOutput("rd_data", app_rd_data, m_data);
  end

  // Log returned read data for the directed literal checks.
  always @(negedge clk_ref_i) begin
    if (app_rd_data_valid) begin
      rsp_log.push_back(app_rd_data);
      rsp_edge.push_back(ecount);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk_ref_i);
      #1;
    end
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a, output int acc_edge);
    bit r;
    acc_edge = -1;
    app_cmd  = c;
    app_addr = a;
    app_en   = 1'b1;
    for (int k = 0; k < 200 && acc_edge < 0; k++) begin
      @(negedge clk_ref_i) r = app_rdy;
      @(posedge clk_ref_i);
      #1;
      if (r) acc_edge = ecount;
    end
    app_en = 1'b0;
    if (acc_edge < 0) checkOutput("cmd_accept_timeout", 0, 1);
  endtask

  task automatic do_wdf(input logic [DATA_W-1:0] d, input logic [15:0] m);
    bit r;
    bit done = 0;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_ref_i) r = app_wdf_rdy;
      @(posedge clk_ref_i);
      #1;
      if (r) done = 1;
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    if (!done) checkOutput("wdf_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n, input int bound);
    for (int k = 0; k < bound && rsp_log.size() < n; k++) begin
      @(posedge clk_ref_i);
      #1;
    end
    checkOutput("rsp_count", rsp_log.size(), n);
  endtask

  task automatic reset_and_init();
    reset_rtl_0  = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wait_cycles(5);
    @(negedge clk_ref_i);
    checkOutput("reset_app_rdy", app_rdy, 0);
    checkOutput("reset_wdf_rdy", app_wdf_rdy, 0);
    checkOutput("reset_valid", app_rd_data_valid, 0);
    checkOutput("reset_rd_data", app_rd_data, 0);
    checkOutput("reset_calib", init_calib_complete, 0);
    checkOutput("reset_err", cmd_err, 0);
    @(posedge clk_ref_i);
    #1;
    reset_rtl_0 = 1'b1;
    repeat (INIT_CYCLES - 1) @(posedge clk_ref_i);
    @(negedge clk_ref_i);
    checkOutput("calib_before_edge64", init_calib_complete, 0);
    checkOutput("rdy_before_calib", app_rdy, 0);
    @(posedge clk_ref_i);
    @(negedge clk_ref_i);
    checkOutput("calib_at_edge64", init_calib_complete, 1);
    @(posedge clk_ref_i);
    #1;
  endtask

  task automatic applyStimulus(input int ncyc);
    logic [ADDR_W-1:0] ra;
    for (int k = 0; k < ncyc; k++) begin
      ra           = ADDR_W'($urandom);
      ra[12:3]     = 10'($urandom_range(0, 15));
      app_addr     = ra;
      app_en       = ($urandom % 3) != 0;
      app_cmd      = 3'($urandom % 2);
      app_wdf_wren = ($urandom % 2) == 1;
      app_wdf_end  = app_wdf_wren;
      app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
      app_wdf_mask = (($urandom % 3) == 0) ? 16'h0 : 16'($urandom);
      @(posedge clk_ref_i);
      #1;
    end
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wait_cycles(30);
  endtask

  initial begin
    int a;
    int acc;
    bit r;

    reset_and_init();

    do_cmd(3'd0, 27'h000_0040, a);
    do_wdf(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h0);
    wait_cycles(4);
    rsp_log.delete();
    rsp_edge.delete();
    do_cmd(3'd1, 27'h000_0040, a);
    wait_rsp(1, 20);
    if (rsp_log.size() > 0) begin
      checkOutput("wr_rd_data", rsp_log[0], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      checkOutput("rd_latency", rsp_edge[0] - a, RD_LAT);
    end

    do_cmd(3'd0, 27'h000_0080, a);
    do_wdf({128{1'b1}}, 16'h0);
    do_cmd(3'd0, 27'h000_0080, a);
    do_wdf(128'h0, 16'h00FF);
    wait_cycles(4);
    rsp_log.delete();
    do_cmd(3'd1, 27'h000_0080, a);
    wait_rsp(1, 20);
    if (rsp_log.size() > 0) begin
      checkOutput("masked_data", rsp_log[0], 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    end

    rsp_log.delete();
    do_cmd(3'd0, 27'h000_00C0, a);
    for (int i = 0; i < 3; i++) do_cmd(3'd1, 27'h000_00C0, a);
    wait_cycles(10);
    checkOutput("no_rsp_before_data", rsp_log.size(), 0);
    do_wdf(128'hA5, 16'h0);
    wait_rsp(3, 20);
    for (int i = 0; i < 3; i++) begin
      if (i < rsp_log.size()) checkOutput("late_data_rsp", rsp_log[i], 128'hA5);
    end

    app_cmd  = 3'd0;
    app_addr = 27'h000_0100;
    app_en   = 1'b1;
    acc      = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_ref_i) r = app_rdy;
      @(posedge clk_ref_i);
      #1;
      if (r) acc++;
    end
    app_en = 1'b0;
    checkOutput("full_accepted", acc, QD);
    @(negedge clk_ref_i);
    checkOutput("full_rdy_low", app_rdy, 0);
    checkOutput("full_no_err", cmd_err, 0);
    @(posedge clk_ref_i);
    #1;
    for (int i = 0; i < QD; i++) do_wdf(128'h1000 + 128'(i), 16'h0);
    wait_cycles(6);

    applyStimulus(3000);

    reset_and_init();
    do_cmd(3'b010, 27'h0, a);
    wait_cycles(2);
    @(negedge clk_ref_i);
    checkOutput("illegal_cmd_err", cmd_err, 1);
    wait_cycles(5);
    @(negedge clk_ref_i);
    checkOutput("err_sticky", cmd_err, 1);

    do_cmd(3'd1, 27'h000_0040, a);
    wait_cycles(1);
    rsp_log.delete();
    reset_rtl_0 = 1'b0;
    wait_cycles(3);
    reset_rtl_0 = 1'b1;
    wait_cycles(15);
    checkOutput("no_valid_after_reset", rsp_log.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
